// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF -> ID -> EX -> WB pipeline sequencing controller.
// Contents: instruction field widths, opcode constants, squash encoding, FSM state enum,
// and the shadow-slot payload that tracks one in-flight instruction.
package pipe_pkg;

  localparam int unsigned INST_W  = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned RD_W    = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_LDI  = 2'b00;
  localparam logic [OP_W-1:0] OP_ADDI = 2'b01;
  localparam logic [OP_W-1:0] OP_NOP  = 2'b10;
  localparam logic [OP_W-1:0] OP_JMP  = 2'b11;

  // Encoding loaded into IF/ID when a wrong-path fetch is squashed.
  localparam logic [INST_W-1:0] NOP_INST = 8'h80;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } state_t;

  // One shadow pipeline slot: valid, destination register, writes-a-register, is-a-jump.
  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            wr;
    logic            jmp;
  } slot_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational opcode decoder.
// Ports:
//   opcode      in  2  instruction bits [7:6]
//   sel1_c      out 1  0 = operand A forced to zero (load-imm)
//   regwrite_c  out 1  instruction writes rd
//   pcsrc_c     out 1  0 = jump, 1 = sequential
//   reads_rd_c  out 1  instruction reads rd as a source (add-imm)
module pipe_ctrl_decode
  import pipe_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            sel1_c,
  output logic            regwrite_c,
  output logic            pcsrc_c,
  output logic            reads_rd_c
);

  always_comb begin
    sel1_c     = 1'b1;
    regwrite_c = 1'b0;
    pcsrc_c    = 1'b1;
    reads_rd_c = 1'b0;
    unique case (opcode)
      OP_LDI: begin
        sel1_c     = 1'b0;
        regwrite_c = 1'b1;
      end
      OP_ADDI: begin
        regwrite_c = 1'b1;
        reads_rd_c = 1'b1;
      end
      OP_NOP: begin
      end
      OP_JMP: begin
        pcsrc_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the IF -> ID -> EX -> WB pipeline: control decode, jump squash,
// EX forwarding select, run/halt/single-step FSM gating fetch, and a retired-instruction counter.
// Ports:
//   clk, reset        clock (rising edge) and synchronous active-low reset
//   run_req/halt_req  level requests to run / stop fetch and drain
//   step_req          pulse; issue one instruction while HALTED
//   if_inst           instruction currently held in IF/ID
//   pc_en             fetch allowed (PC and IF/ID load enable)
//   ifid_flush        force IF/ID to NOP_INST at the next edge
//   sel1/regwrite/pcsrc  control for the instruction now in EX
//   fwd_sel           EX operand A taken from the EX/WB result
//   busy              any pipeline stage holds a valid instruction
//   state             FSM state
//   retired           count of valid instructions leaving WB (wraps)
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_req,
  input  logic                halt_req,
  input  logic                step_req,
  input  logic [INST_W-1:0]   if_inst,
  output logic                pc_en,
  output logic                ifid_flush,
  output logic                sel1,
  output logic                regwrite,
  output logic                pcsrc,
  output logic                fwd_sel,
  output logic                busy,
  output logic [STATE_W-1:0]  state,
  output logic [CNT_W-1:0]    retired
);

  state_t          state_q, state_nxt;
  logic            pc_en_nxt;
  logic            v_id, v_wb;
  slot_t           ex_q, ex_nxt;
  logic            dec_sel1, dec_regwrite, dec_pcsrc, dec_reads_rd;
  logic [RD_W-1:0] rd_id;
  logic            squash_c, id_ok_c, v_id_nxt, fwd_nxt;
  logic            unused_imm;

  pipe_ctrl_decode u_decode (
    .opcode     (if_inst[INST_W-1 -: OP_W]),
    .sel1_c     (dec_sel1),
    .regwrite_c (dec_regwrite),
    .pcsrc_c    (dec_pcsrc),
    .reads_rd_c (dec_reads_rd)
  );

  assign rd_id      = if_inst[5:3];
  assign unused_imm = ^if_inst[2:0];

  // A jump in EX kills the instruction in ID and the fetch landing this cycle.
  assign squash_c = ex_q.v & ex_q.jmp;
  assign id_ok_c  = v_id & ~squash_c;
  assign v_id_nxt = pc_en & ~squash_c;
  assign ex_nxt   = {id_ok_c, rd_id, dec_regwrite, ~dec_pcsrc};

  // Add-imm in ID reading the register the EX instruction is about to write.
  assign fwd_nxt  = id_ok_c & dec_reads_rd & ex_q.v & ex_q.wr & (ex_q.rd == rd_id);

  // Next-state and fetch-enable logic.
  always_comb begin
    state_nxt = state_q;
    pc_en_nxt = 1'b0;
    unique case (state_q)
      IDLE:    if (run_req) state_nxt = RUN;
      RUN:     if (halt_req) state_nxt = DRAIN;
      DRAIN:   if (!busy) state_nxt = HALTED;
      HALTED: begin
        if (run_req)       state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      STEP:    state_nxt = DRAIN;
      default: state_nxt = IDLE;
    endcase
    pc_en_nxt = (state_nxt == RUN) || (state_nxt == STEP);
  end

  // State, shadow slots and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_en      <= 1'b0;
      ifid_flush <= 1'b0;
      sel1       <= 1'b1;
      regwrite   <= 1'b0;
      pcsrc      <= 1'b1;
      fwd_sel    <= 1'b0;
      busy       <= 1'b0;
      retired    <= '0;
      v_id       <= 1'b0;
      ex_q       <= '0;
      v_wb       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      pc_en      <= pc_en_nxt;
      v_id       <= v_id_nxt;
      ex_q       <= ex_nxt;
      v_wb       <= ex_q.v;
      ifid_flush <= ex_nxt.v & ex_nxt.jmp;
      sel1       <= dec_sel1;
      regwrite   <= ex_nxt.v & ex_nxt.wr;
      pcsrc      <= ~(ex_nxt.v & ex_nxt.jmp);
      fwd_sel    <= fwd_nxt;
      busy       <= v_id_nxt | ex_nxt.v | ex_q.v;
      retired    <= retired + CNT_W'(v_wb);
    end
  end

  assign state = state_q;

endmodule
